// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern generator.
// Covers the display mode encoding and the pattern each mode starts from.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_t;

  localparam int NUM_MODES = 4;

  // Widest LED bank the pattern helper can describe; N_LED must not exceed it.
  localparam int MAX_LED = 64;

  function automatic logic [MAX_LED-1:0] init_pattern(input mode_t m, input int n);
    logic [MAX_LED-1:0] p;
    p = '0;
    if ((m == MODE_SHIFT || m == MODE_BOUNCE) && n >= 1) begin
      p[0] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/led_pattern_gen_btn.sv
// Button conditioning: two-flop synchroniser, debounce counter and a
// one-cycle press pulse on a debounced 0->1 transition.
module btn_debounce
  import led_pkg::*;
#(
  parameter int DB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);

  logic          sync0;
  logic          bsync;
  logic          stable;
  logic [CW-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      bsync <= 1'b0;
    end else begin
      sync0 <= btn;
      bsync <= sync0;
    end
  end

  // A press is only reported when the stable level itself rises, so release
  // and a held button never produce a further event.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (bsync == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        stable <= bsync;
        press  <= bsync;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Four-mode LED pattern generator stepped by a prescaled tick, with a
// debounced button cycling BLINK -> SHIFT -> BOUNCE -> COUNT -> BLINK.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_LED    = 8,
  parameter int TICK_DIV = 50_000_000,
  parameter int DB_CYC   = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  output logic [N_LED-1:0] led,
  output logic [1:0]       mode
);

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    pcnt;
  logic             tick;
  logic             press;
  logic             dir;
  logic             dir_next;
  mode_t            mode_q;
  mode_t            mode_next;
  logic [N_LED-1:0] init_led;
  logic [N_LED-1:0] step_led;

  btn_debounce #(
    .DB_CYC(DB_CYC)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .press(press)
  );

  assign tick      = (pcnt == TICK_LAST);
  assign mode_next = (mode_q == mode_t'(NUM_MODES - 1)) ? MODE_BLINK
                                                        : mode_t'(mode_q + 2'd1);
  assign init_led  = N_LED'(init_pattern(mode_next, N_LED));
  assign mode      = mode_q;

  // Next pattern for a tick; a single-LED bank has nowhere to bounce to.
  always_comb begin
    step_led = led;
    dir_next = dir;
    case (mode_q)
      MODE_BLINK:  step_led = ~led;
      MODE_SHIFT:  step_led = (led << 1) | (led >> (N_LED - 1));
      MODE_BOUNCE: begin
        if (N_LED > 1) begin
          if (dir == DIR_LEFT) begin
            step_led = led << 1;
            if (step_led[N_LED-1]) dir_next = DIR_RIGHT;
          end else begin
            step_led = led >> 1;
            if (step_led[0]) dir_next = DIR_LEFT;
          end
        end
      end
      MODE_COUNT:  step_led = led + 1'b1;
      default:     step_led = led;
    endcase
  end

  // A press overrides a coincident tick and restarts the prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt   <= '0;
      mode_q <= MODE_BLINK;
      dir    <= DIR_LEFT;
      led    <= '0;
    end else if (press) begin
      pcnt   <= '0;
      mode_q <= mode_next;
      dir    <= DIR_LEFT;
      led    <= init_led;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        led <= step_led;
        dir <= dir_next;
      end
    end
  end

endmodule
